// File: rtl/fpu_divider_if.sv
// -----------------------------------------------------------------------------
// fpu_divider_if
//   Request/response bundle for the sequential mantissa divider.
//
//   Handshake: the requester drives divIn1/divIn2 and pulses start for one
//   cycle. The divider accepts start only when it is not busy (idle or
//   holding a result). The operands are captured on the accepting edge. busy
//   is high while iterating. done is high while the result is held. The
//   result fields are meaningful only while done is high.
//
//   Signals:
//     divIn1   requester -> divider  dividend mantissa A (hidden bit included)
//     divIn2   requester -> divider  divisor mantissa B (hidden bit included)
//     start    requester -> divider  one-cycle request pulse
//     quotient divider -> requester  floor(A * 2^(FRAC_WIDTH+2) / B)
//     sticky   divider -> requester  final remainder non-zero
//     divZero  divider -> requester  B was zero at start
//     busy     divider -> requester  iterating
//     done     divider -> requester  result valid and held
// -----------------------------------------------------------------------------
`ifndef FP16_FRACW
`define FP16_FRACW 10
`endif

interface fpu_divider_if #(
    parameter int FRAC_WIDTH = `FP16_FRACW
);
    logic [FRAC_WIDTH:0]   divIn1;
    logic [FRAC_WIDTH:0]   divIn2;
    logic                  start;
    logic [FRAC_WIDTH+2:0] quotient;
    logic                  sticky;
    logic                  divZero;
    logic                  busy;
    logic                  done;

    modport master (
        output divIn1, divIn2, start,
        input  quotient, sticky, divZero, busy, done
    );

    modport slave (
        input  divIn1, divIn2, start,
        output quotient, sticky, divZero, busy, done
    );
endinterface

// File: rtl/fpu_divider.sv
// -----------------------------------------------------------------------------
// fpu_divider
//   Unsigned restoring divider for floating-point mantissas. It produces one
//   quotient bit per clock, for N = FRAC_WIDTH+3 bits in total: the MSB is the
//   integer bit and the LSB is the guard bit. It also reports a sticky flag
//   for the rounding stage. The divider can be restarted straight from the
//   result-holding state.
//
//   Ports:
//     clock        rising-edge clock
//     reset_n      asynchronous active-low reset
//     bus          fpu_divider_if slave (operands, start, results, busy/done)
//     o_dbg_state  current FSM state (0 = WAIT, 1 = COMP, 2 = DONE)
// -----------------------------------------------------------------------------
`ifndef FP16_FRACW
`define FP16_FRACW 10
`endif

module fpu_divider #(
    parameter int FRAC_WIDTH = `FP16_FRACW
) (
    input  logic               clock,
    input  logic               reset_n,
    fpu_divider_if.slave       bus,
    output logic [1:0]         o_dbg_state
);

    localparam int N  = FRAC_WIDTH + 3;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    typedef enum logic [1:0] {
        DIV_WAIT = 2'd0,
        DIV_COMP = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    div_state_t              r_state;
    div_state_t              w_next_state;

    logic [FRAC_WIDTH:0]     r_b;
    logic [FRAC_WIDTH+1:0]   r_rem;
    logic [N-1:0]            r_quot;
    logic [CW-1:0]           r_cnt;
    logic                    r_sticky;
    logic                    r_divzero;

    logic                    w_accept;
    logic                    w_b_zero;
    logic                    w_ge;
    logic [FRAC_WIDTH+1:0]   w_diff;
    logic [FRAC_WIDTH+1:0]   w_rem_sub;
    logic                    w_last;

    // start is honoured everywhere except mid-iteration.
    assign w_accept  = bus.start && (r_state != DIV_COMP);
    assign w_b_zero  = (bus.divIn2 == '0);

    // One restoring step: subtract when it does not go negative.
    assign w_ge      = (r_rem >= {1'b0, r_b});
    assign w_diff    = r_rem - {1'b0, r_b};
    assign w_rem_sub = w_ge ? w_diff : r_rem;
    assign w_last    = (r_cnt == LAST_ITER);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= DIV_WAIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DIV_WAIT: begin
                if (bus.start) begin
                    w_next_state = w_b_zero ? DIV_DONE : DIV_COMP;
                end
            end
            DIV_COMP: begin
                if (w_last) begin
                    w_next_state = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (bus.start) begin
                    w_next_state = w_b_zero ? DIV_DONE : DIV_COMP;
                end
            end
            default: w_next_state = DIV_WAIT;
        endcase
    end

    // Datapath.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_b       <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_cnt     <= '0;
            r_sticky  <= 1'b0;
            r_divzero <= 1'b0;
        end else if (w_accept) begin
            r_b       <= bus.divIn2;
            r_rem     <= {1'b0, bus.divIn1};
            r_cnt     <= '0;
            r_sticky  <= 1'b0;
            r_divzero <= w_b_zero;
            // A zero divisor saturates the quotient immediately; no iterations run.
            r_quot    <= w_b_zero ? '1 : '0;
        end else if (r_state == DIV_COMP) begin
            r_quot <= {r_quot[N-2:0], w_ge};
            // With A < 2B the post-subtract remainder is below B, so its MSB
            // is zero and dropping it in the shift loses nothing.
            r_rem  <= {w_rem_sub[FRAC_WIDTH:0], 1'b0};
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
                r_sticky <= |w_rem_sub;
            end
        end
    end

    assign bus.quotient = r_quot;
    assign bus.sticky   = r_sticky;
    assign bus.divZero  = r_divzero;
    assign bus.busy     = (r_state == DIV_COMP);
    assign bus.done     = (r_state == DIV_DONE);
    assign o_dbg_state  = r_state;

endmodule
